// File: rtl/mask_mov_engine_if.sv
// Bundle of command, arbitration and result signals between the mask move
// engine and its user.
//   master : issues commands, sees the result/strobe (testbench or sequencer)
//   slave  : the engine itself
// Signals:
//   cmd_valid/cmd_ready        command handshake
//   cmd_src/cmd_amt            source mask and shift amount
//   cmd_dir/cmd_rot            0 = left / 1 = right; 1 = rotate, 0 = zero-fill
//   pim_load_in                copy of the mask register's PIM_load
//   MOV_out/Mov_load           result mask and load strobe to the mask register
//   busy/err_amt               engine not idle; rejected-command pulse
interface mask_mov_engine_if #(
  parameter int unsigned N   = 10,
  parameter int unsigned SHW = 4
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [N-1:0]   cmd_src;
  logic [SHW-1:0] cmd_amt;
  logic           cmd_dir;
  logic           cmd_rot;
  logic           pim_load_in;
  logic [N-1:0]   MOV_out;
  logic           Mov_load;
  logic           busy;
  logic           err_amt;

  modport master (
    output cmd_valid, cmd_src, cmd_amt, cmd_dir, cmd_rot, pim_load_in,
    input  cmd_ready, MOV_out, Mov_load, busy, err_amt
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_amt, cmd_dir, cmd_rot, pim_load_in,
    output cmd_ready, MOV_out, Mov_load, busy, err_amt
  );
endinterface

// File: rtl/mask_mov_engine.sv
// Source side of the mask register's move path. Accepts a move command, shifts
// or rotates the source mask one bit per cycle, then presents the result with
// a load strobe held until the mask register actually takes it (PIM_load has
// priority in the mask register, so the strobe is held while pim_load_in = 1).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mask_mov_engine_if slave modport (command, arbitration, result)
module mask_mov_engine #(
  parameter int unsigned N   = 10,
  parameter int unsigned SHW = 4
) (
  input logic                clk,
  input logic                rst_n,
  mask_mov_engine_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   work_q, work_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           rot_q, rot_d;
  logic           load_q, load_d;
  logic           err_q, err_d;

  logic [N-1:0]   shifted;
  logic           amt_too_big;

  // Full-width compare: no truncation of cmd_amt before checking against N.
  assign amt_too_big = (32'(bus.cmd_amt) >= N);

  // One single-bit step according to the latched direction and mode.
  always_comb begin
    shifted = work_q;
    if (!dir_q) begin
      shifted = {work_q[N-2:0], rot_q ? work_q[N-1] : 1'b0};
    end else begin
      shifted = {rot_q ? work_q[0] : 1'b0, work_q[N-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (amt_too_big) begin
            // Rejected: working register untouched, stay idle.
            err_d = 1'b1;
          end else begin
            work_d  = bus.cmd_src;
            cnt_d   = bus.cmd_amt;
            dir_d   = bus.cmd_dir;
            rot_d   = bus.cmd_rot;
            state_d = (bus.cmd_amt == '0) ? StLoad : StShift;
          end
        end
      end
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        // PIM_load won this cycle: the move did not land, keep retrying.
        if (!bus.pim_load_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_d = (state_d == StLoad);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.MOV_out   = work_q;
  assign bus.Mov_load  = load_q;
  assign bus.err_amt   = err_q;

endmodule

// File: tb/tb_mask_mov_engine.sv
module tb_mask_mov_engine;

  typedef struct {
    bit         is_err;
    logic [9:0] mov;
    int         len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mask_mov_engine_if #(.N(10), .SHW(4)) bus ();

  mask_mov_engine #(.N(10), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  logic prev_load = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) chk("cmd_ready timeout", 0, 1);
  endtask

  // Drives a command starting at a negedge; returns at the negedge after the
  // accepting posedge.
  task automatic send(input logic [9:0] src, input logic [3:0] amt,
                      input logic dir, input logic rot);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = src;
    bus.cmd_amt   = amt;
    bus.cmd_dir   = dir;
    bus.cmd_rot   = rot;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_load(input logic [9:0] mov, input int len);
    exp_t e;
    e.is_err = 1'b0;
    e.mov    = mov;
    e.len    = len;
    sb.push_back(e);
  endtask

  task automatic expect_err(input logic [9:0] mov);
    exp_t e;
    e.is_err = 1'b1;
    e.mov    = mov;
    e.len    = 0;
    sb.push_back(e);
  endtask

  // Monitor: pops expected results on err_amt pulses and Mov_load pulses.
  initial begin : monitor
    exp_t cur;
    exp_t it;
    int   len;
    len = 0;
    cur.is_err = 1'b0;
    cur.mov    = '0;
    cur.len    = 0;
    forever begin
      @(negedge clk);
      if (bus.err_amt) begin
        if (sb.size() == 0) begin
          chk("unexpected err_amt", 1, 0);
        end else begin
          it = sb.pop_front();
          chk("err kind", 32'(it.is_err), 1);
          chk("err MOV_out held", 32'(bus.MOV_out), 32'(it.mov));
          chk("err cmd_ready", 32'(bus.cmd_ready), 1);
        end
      end
      if (bus.Mov_load && !prev_load) begin
        if (sb.size() == 0 || sb[0].is_err) begin
          chk("unexpected Mov_load", 1, 0);
          cur.mov = bus.MOV_out;
          cur.len = -1;
        end else begin
          cur = sb.pop_front();
        end
        len = 0;
      end
      if (bus.Mov_load) begin
        len++;
        chk("load MOV_out", 32'(bus.MOV_out), 32'(cur.mov));
      end else if (prev_load) begin
        chk("load length", 32'(len), 32'(cur.len));
      end
      prev_load = bus.Mov_load;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.cmd_valid   = 1'b0;
    bus.cmd_src     = '0;
    bus.cmd_amt     = '0;
    bus.cmd_dir     = 1'b0;
    bus.cmd_rot     = 1'b0;
    bus.pim_load_in = 1'b0;

    // Reset held two cycles, then idle for 20 with nothing changing.
    repeat (2) @(negedge clk);
    chk("reset outputs", {bus.MOV_out, bus.Mov_load, bus.cmd_ready, bus.busy, bus.err_amt},
        {10'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle outputs", {bus.MOV_out, bus.Mov_load, bus.cmd_ready, bus.busy, bus.err_amt},
          {10'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end

    // Left logical 3 with explicit latency checks.
    expect_load(10'b0000111000, 1);
    send(10'b0000000111, 4'd3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("lsl3 strobe not early", 32'(bus.Mov_load), 0);
    @(negedge clk);
    chk("lsl3 strobe at E+3", 32'(bus.Mov_load), 1);
    chk("lsl3 not ready in LOAD", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("lsl3 ready after load", 32'(bus.cmd_ready), 1);

    // Amount 0: strobe in the cycle right after accept.
    expect_load(10'b0000000111, 1);
    send(10'b0000000111, 4'd0, 1'b0, 1'b0);
    chk("amt0 strobe at E", 32'(bus.Mov_load), 1);
    chk("amt0 result", 32'(bus.MOV_out), 32'(10'b0000000111));

    expect_load(10'b1000000000, 1);
    send(10'b0000000001, 4'd1, 1'b1, 1'b1);   // rotate right 1
    expect_load(10'b0100000000, 1);
    send(10'b1000000000, 4'd9, 1'b0, 1'b1);   // rotate left 9
    expect_load(10'b0010000000, 1);
    send(10'b1000000011, 4'd2, 1'b1, 1'b0);   // logical right 2
    expect_load(10'b1000000000, 1);
    send(10'b1010101011, 4'd9, 1'b0, 1'b0);   // logical left N-1

    // Rejects (boundary N and 12), then a command on the very next edge.
    wait_ready();
    expect_err(10'b1000000000);
    send(10'b1111111111, 4'd10, 1'b0, 1'b0);
    expect_err(10'b1000000000);
    send(10'b1111111111, 4'd12, 1'b0, 1'b0);
    expect_load(10'b0000000110, 1);
    send(10'b0000000011, 4'd1, 1'b0, 1'b1);
    chk("accept after reject", 32'(bus.busy), 1);

    // Collision: pim_load_in high for 3 cycles starting in LOAD.
    expect_load(10'b0101010101, 4);
    send(10'b0101010101, 4'd0, 1'b0, 1'b0);
    bus.pim_load_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("collision still loading", 32'(bus.Mov_load), 1);
    bus.pim_load_in = 1'b0;
    @(negedge clk);
    chk("collision back to idle", 32'(bus.cmd_ready), 1);

    // Reset after 3 of 7 shifts: command discarded, no strobe afterwards.
    send(10'b0000000001, 4'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid-shift busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("shift reset outputs", {bus.MOV_out, bus.Mov_load, bus.cmd_ready, bus.busy},
        {10'b0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Reset during a stretched LOAD (strobe seen for 2 cycles, then cut).
    expect_load(10'b0000001100, 2);
    send(10'b0000000011, 4'd2, 1'b0, 1'b0);
    bus.pim_load_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("stretched load active", 32'(bus.Mov_load), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("load reset outputs", {bus.MOV_out, bus.Mov_load, bus.cmd_ready, bus.busy},
        {10'b0, 1'b0, 1'b1, 1'b0});
    bus.pim_load_in = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Normal operation after reset.
    expect_load(10'b0010000000, 1);
    send(10'b0000000001, 4'd3, 1'b1, 1'b1);   // rotate right 3

    begin
      int t = 0;
      while ((sb.size() != 0 || prev_load) && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
